// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder: captures a request vector and emits one
// beat per set bit, highest-first (mode=0) or lowest-first (mode=1).
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   request vector offered
//   in_ready   block can capture a vector this cycle (IDLE only)
//   in_vec     request vector, bit i = request on line i
//   mode       0 = highest index first, 1 = lowest index first
//   out_valid  out_idx/out_zero/out_last are valid
//   out_ready  downstream accepts the current beat
//   out_idx    index of the current winning bit
//   out_zero   captured vector was all-zero
//   out_last   current beat is the final one for the captured vector
//   pend_cnt   set bits still pending, including the current beat
module priority_encoder_seq #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_zero,
    output logic             out_last,
    output logic [IDX_W:0]   pend_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] pend_vec;
    logic [WIDTH-1:0] clr_vec;
    logic             mode_q;
    logic             zero_q;

    logic             cap;
    logic             xfer;
    logic             last_i;

    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W:0]   cnt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and handshake outputs. in_ready is masked by rst so it
    // reads 0 for the whole reset window, not only after the first edge.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        cap       = 1'b0;
        xfer      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = !rst;
                cap      = in_valid && !rst;
                if (cap) begin
                    state_nx = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                xfer      = out_ready;
                if (out_ready && last_i) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Highest and lowest set index of the pending vector. Both scans only
    // ever assign indices below WIDTH, so non-power-of-two widths cannot
    // produce an out-of-range winner.
    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pend_vec[i]) begin
                hi_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        lo_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_vec[i]) begin
                lo_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + (IDX_W + 1)'(pend_vec[i]);
        end
    end

    assign win_idx = mode_q ? lo_idx : hi_idx;

    // Single-bit mask of the winner, built by compare so that the bit
    // select never needs an index wider than the vector.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (IDX_W'(i) == win_idx) begin
                clr_vec[i] = 1'b1;
            end
        end
    end

    // An all-zero capture still produces one beat, flagged via zero_q.
    assign last_i = zero_q || (cnt == (IDX_W + 1)'(1));

    // Captured vector and per-capture flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vec <= '0;
            mode_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else if (cap) begin
            pend_vec <= in_vec;
            mode_q   <= mode;
            zero_q   <= (in_vec == '0);
        end else if (xfer) begin
            pend_vec <= pend_vec & ~clr_vec;
            if (last_i) begin
                zero_q <= 1'b0;
            end
        end
    end

    // Beat outputs depend on registered state only.
    always_comb begin
        out_idx  = '0;
        out_zero = 1'b0;
        out_last = 1'b0;
        pend_cnt = '0;
        if (state == EMIT) begin
            out_idx  = win_idx;
            out_zero = zero_q;
            out_last = last_i;
            pend_cnt = cnt;
        end
    end

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Scoreboard bench for priority_encoder_seq at WIDTH=8 and WIDTH=12.
// Expected beats are queued at capture and compared on each transfer.
module tb_priority_encoder_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic       a_in_valid;
    logic       a_in_ready;
    logic [7:0] a_in_vec;
    logic       a_mode;
    logic       a_out_valid;
    logic       a_out_ready;
    logic [2:0] a_out_idx;
    logic       a_out_zero;
    logic       a_out_last;
    logic [3:0] a_pend_cnt;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [11:0] b_in_vec;
    logic        b_mode;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [3:0]  b_out_idx;
    logic        b_out_zero;
    logic        b_out_last;
    logic [4:0]  b_pend_cnt;

    priority_encoder_seq #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (a_in_valid),
        .in_ready (a_in_ready),
        .in_vec   (a_in_vec),
        .mode     (a_mode),
        .out_valid(a_out_valid),
        .out_ready(a_out_ready),
        .out_idx  (a_out_idx),
        .out_zero (a_out_zero),
        .out_last (a_out_last),
        .pend_cnt (a_pend_cnt)
    );

    priority_encoder_seq #(.WIDTH(12)) u_dut12 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .in_vec   (b_in_vec),
        .mode     (b_mode),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .out_idx  (b_out_idx),
        .out_zero (b_out_zero),
        .out_last (b_out_last),
        .pend_cnt (b_pend_cnt)
    );

    typedef struct {
        int idx;
        bit zero;
        bit last;
        int cnt;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];

    int checks   = 0;
    int failures = 0;
    int a_beats  = 0;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
        end
    endtask

    // Reference order of beats for one captured vector
    function automatic void model(input int sel, input logic [63:0] v,
                                  input int w, input bit m);
        int    n;
        int    i;
        beat_t b;
        n = 0;
        for (int k = 0; k < w; k++) begin
            if (v[k]) n++;
        end
        if (n == 0) begin
            b = '{idx: 0, zero: 1'b1, last: 1'b1, cnt: 0};
            if (sel == 0) qa.push_back(b);
            else qb.push_back(b);
        end else begin
            for (int k = 0; k < w; k++) begin
                i = m ? k : w - 1 - k;
                if (v[i]) begin
                    b = '{idx: i, zero: 1'b0, last: (n == 1), cnt: n};
                    if (sel == 0) qa.push_back(b);
                    else qb.push_back(b);
                    n--;
                end
            end
        end
    endfunction

    // Monitor for the 8-bit instance
    bit         pa_hold;
    bit         pa_last;
    bit         pa_mid;
    logic [2:0] pa_idx;
    logic       pa_zero;
    logic       pa_lst;
    logic [3:0] pa_cnt;

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            pa_hold = 0;
            pa_last = 0;
            pa_mid  = 0;
        end else begin
            if (a_in_valid && a_in_ready)
                model(0, 64'(a_in_vec), 8, a_mode);
            if (pa_last) begin
                chk("a_ready_after_last", a_in_ready, 1);
                chk("a_idle_after_last", a_out_valid, 0);
            end
            if (pa_mid) chk("a_consecutive", a_out_valid, 1);
            if (a_out_valid) chk("a_ready_in_emit", a_in_ready, 0);
            if (pa_hold) begin
                chk("a_hold_idx", a_out_idx, pa_idx);
                chk("a_hold_zero", a_out_zero, pa_zero);
                chk("a_hold_last", a_out_last, pa_lst);
                chk("a_hold_cnt", a_pend_cnt, pa_cnt);
            end
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_beat", 1, 0);
                end else begin
                    e = qa.pop_front();
                    chk("a_idx", a_out_idx, e.idx);
                    chk("a_zero", a_out_zero, e.zero);
                    chk("a_last", a_out_last, e.last);
                    chk("a_cnt", a_pend_cnt, e.cnt);
                end
                a_beats++;
            end
            pa_hold = a_out_valid && !a_out_ready;
            pa_idx  = a_out_idx;
            pa_zero = a_out_zero;
            pa_lst  = a_out_last;
            pa_cnt  = a_pend_cnt;
            pa_last = a_out_valid && a_out_ready && a_out_last;
            pa_mid  = a_out_valid && a_out_ready && !a_out_last
                      && a_out_ready;
        end
    end

    // Monitor for the 12-bit instance
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (b_in_valid && b_in_ready)
                model(1, 64'(b_in_vec), 12, b_mode);
            if (b_out_valid)
                chk("b_idx_range", b_out_idx > 4'd11, 0);
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_beat", 1, 0);
                end else begin
                    e = qb.pop_front();
                    chk("b_idx", b_out_idx, e.idx);
                    chk("b_zero", b_out_zero, e.zero);
                    chk("b_last", b_out_last, e.last);
                    chk("b_cnt", b_pend_cnt, e.cnt);
                end
            end
        end
    end

    task automatic send_a(input logic [7:0] v, input bit m);
        @(posedge clk);
        #1;
        a_in_valid = 1'b1;
        a_in_vec   = v;
        a_mode     = m;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (a_in_ready) break;
            if (t == 59) chk("a_send_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("a_latency", a_out_valid, 1);
    endtask

    task automatic drain_a(input bit rnd);
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            #1;
            if (rnd) a_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (qa.size() == 0 && !a_out_valid) break;
            if (t == 299) chk("a_drain_timeout", 0, 1);
        end
        a_out_ready = 1'b1;
    endtask

    task automatic send_b(input logic [11:0] v, input bit m);
        @(posedge clk);
        #1;
        b_in_valid = 1'b1;
        b_in_vec   = v;
        b_mode     = m;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (b_in_ready) break;
            if (t == 59) chk("b_send_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain_b(input bit rnd);
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            #1;
            if (rnd) b_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (qb.size() == 0 && !b_out_valid) break;
            if (t == 299) chk("b_drain_timeout", 0, 1);
        end
        b_out_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=0 exp=1");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        a_in_valid  = 1'b0;
        a_in_vec    = '0;
        a_mode      = 1'b0;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_vec    = '0;
        b_mode      = 1'b0;
        b_out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_idx", a_out_idx, 0);
        chk("rst_out_zero", a_out_zero, 0);
        chk("rst_out_last", a_out_last, 0);
        chk("rst_pend_cnt", a_pend_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", a_in_ready, 1);

        // 1010_0100 both directions
        send_a(8'b1010_0100, 1'b0);
        drain_a(1'b0);
        send_a(8'b1010_0100, 1'b1);
        drain_a(1'b0);

        // All-zero capture
        send_a(8'h00, 1'b0);
        drain_a(1'b0);

        // Back-pressure with ignored in_valid pulses
        a_out_ready = 1'b0;
        send_a(8'h80, 1'b0);
        chk("bp_idx_c1", a_out_idx, 7);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            a_in_valid = (i == 0);
            a_in_vec   = 8'hFF;
            a_mode     = 1'b1;
            @(negedge clk);
            chk("bp_valid", a_out_valid, 1);
            chk("bp_idx", a_out_idx, 7);
        end
        @(posedge clk);
        #1;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        drain_a(1'b0);
        chk("bp_queue_empty", qa.size(), 0);

        // Reset in the middle of an all-ones burst
        a_beats = 0;
        send_a(8'hFF, 1'b0);
        for (int t = 0; t < 50 && a_beats < 2; t++) @(negedge clk);
        chk("mid_rst_beats", a_beats, 2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", a_out_valid, 0);
        chk("mid_rst_ready", a_in_ready, 0);
        chk("mid_rst_cnt", a_pend_cnt, 0);
        qa.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", a_in_ready, 1);
        chk("post_rst_valid", a_out_valid, 0);
        send_a(8'h01, 1'b0);
        drain_a(1'b0);
        send_a(8'hFF, 1'b1);
        drain_a(1'b0);

        // Random traffic on the 8-bit instance
        for (int n = 0; n < 12; n++) begin
            send_a(8'($urandom), 1'($urandom_range(0, 1)));
            drain_a(1'b1);
        end

        // 12-bit instance, non-power-of-two width
        send_b(12'h801, 1'b0);
        drain_b(1'b0);
        send_b(12'hFFF, 1'b1);
        drain_b(1'b0);
        for (int n = 0; n < 20; n++) begin
            send_b(12'($urandom), 1'($urandom_range(0, 1)));
            drain_b(1'b1);
        end

        chk("a_queue_final", qa.size(), 0);
        chk("b_queue_final", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/priority_encoder_seq.md
PRIORITY_ENCODER_SEQ -- requirements
Module: priority_encoder_seq

Interface
REQ-001 Parameter WIDTH, default 8: request vector width; legal range 2..64.
REQ-002 Parameter IDX_W, default $clog2(WIDTH): width of index and count outputs; never overridden by instantiators.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request vector offered.
REQ-006 in_ready  output  1  block accepts a vector this cycle.
REQ-007 in_vec  input  WIDTH  request vector; bit i set = request on line i.
REQ-008 mode  input  1  0 = MSB-first (highest index wins), 1 = LSB-first; sampled with in_vec.
REQ-009 out_valid  output  1  out_idx/out_zero/out_last valid.
REQ-010 out_ready  input  1  downstream accepts current beat.
REQ-011 out_idx  output  IDX_W  index of the current winning bit.
REQ-012 out_zero  output  1  the captured vector was all-zero.
REQ-013 out_last  output  1  current beat is the final beat for the captured vector.
REQ-014 pend_cnt  output  IDX_W+1  number of set bits still pending, including the current beat.

Function
REQ-015 The block SHALL have two states: IDLE and EMIT.
REQ-016 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-017 A capture SHALL occur when in_valid and in_ready are both 1; at that edge the block SHALL register in_vec into pend_vec, register mode into mode_q, set zero_q = (in_vec == 0), and go to EMIT.
REQ-018 After a capture at edge k, out_valid SHALL be 1 from cycle k+1 (latency 1).
REQ-019 In EMIT, in_ready SHALL be 0, and in_valid/in_vec/mode SHALL be ignored.
REQ-020 In EMIT, out_valid SHALL be 1 and out_idx SHALL be the highest set index of pend_vec when mode_q = 0, or the lowest set index when mode_q = 1.
REQ-021 A beat SHALL transfer when out_valid and out_ready are both 1; on transfer the block SHALL clear bit out_idx in pend_vec.
REQ-022 While out_valid = 1 and out_ready = 0, out_idx, out_zero, out_last and pend_cnt SHALL hold stable.
REQ-023 out_last SHALL be 1 when pend_vec has exactly one set bit, or when zero_q = 1.
REQ-024 A transfer with out_last = 1 SHALL return the block to IDLE at that edge.
REQ-025 There SHALL be one IDLE cycle (a bubble) between the last beat and the next capture; back-to-back capture is not supported.
REQ-026 All-zero capture: the block SHALL emit exactly one beat with out_idx = 0, out_zero = 1, out_last = 1, pend_cnt = 0.
REQ-027 For a non-zero capture, out_zero SHALL be 0 on every beat.
REQ-028 pend_cnt SHALL equal popcount(pend_vec) in EMIT and 0 in IDLE.
REQ-029 For all-ones WIDTH-bit input, the block SHALL emit exactly WIDTH beats, with out_idx covering 0..WIDTH-1 with no repeats.
REQ-030 When WIDTH is not a power of two, out_idx SHALL never exceed WIDTH-1.
REQ-031 out_idx and out_last SHALL be combinational from registered state only, with no path from in_* or out_ready.

Reset
REQ-032 While rst = 1, state SHALL be IDLE, pend_vec = 0, zero_q = 0, mode_q = 0, out_valid = 0, out_idx = 0, out_zero = 0, out_last = 0, pend_cnt = 0 and in_ready = 0.
REQ-033 Reset SHALL take effect immediately on assertion, without waiting for a clock edge.
REQ-034 Reset asserted mid-EMIT SHALL discard pending bits, with no further beats emitted.
REQ-035 in_ready SHALL rise in the first cycle after rst deasserts.

Verification
REQ-036 WIDTH=8, in_vec=8'b1010_0100, mode=0, out_ready=1 -> out_idx 7,5,2 on three consecutive cycles; pend_cnt 3,2,1; out_last only on 2.
REQ-037 Same vector with mode=1 -> out_idx 2,5,7; out_last on 7; in_ready returns to 1 on the cycle after the last beat.
REQ-038 in_vec=8'h00 -> exactly one beat with out_idx=0, out_zero=1, out_last=1, pend_cnt=0; then IDLE.
REQ-039 in_vec=8'h80, mode=0, out_ready held 0 for 3 cycles -> out_valid=1 and out_idx=7 stable for all 3 cycles; transfer on the 4th cycle; in_valid pulses during EMIT have no effect.
REQ-040 in_vec=8'hFF, rst asserted after the 2nd beat, between clock edges -> out_valid=0 immediately; after deassert, in_ready=1 and a new capture of 8'h01 yields a single beat with out_idx=0.
REQ-041 WIDTH=12, in_vec=12'h801, mode=0 -> out_idx 11 then 0; pend_cnt 2 then 1; out_idx never exceeds 11 under random stimulus.
